// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: the writeback record handed to
// the writeback arbiter, the stage FSM encoding and the latched request.
package mem_stage_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int REG_ADR_W = 3;

    // Register-write record consumed by the writeback arbiter.
    typedef struct packed {
        logic                 ena;
        logic [REG_ADR_W-1:0] adr;
        logic [DATA_W-1:0]    data;
    } signal_mem_wr_reg;

    localparam signal_mem_wr_reg MEM_WR_NONE = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } mem_state_e;

    // Request captured from execute at acceptance; held for the whole bus
    // transaction so the bus sees stable address/data.
    typedef struct packed {
        logic                 we;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    wdata;
        logic [REG_ADR_W-1:0] rd;
    } mem_req_t;

endpackage

// File: rtl/mem_stage_timeout_cnt.sv
// Bus-timeout counter: cleared when a request is issued, counts REQ cycles
// without ack, and flags the cycle in which it has reached LIMIT-1.
module mem_timeout_cnt #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins, then saturate at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: accepts one load/store from execute, runs a req/ack
// bus transaction, and presents a one-cycle register-write record for loads.
//
// Handshake: an op is accepted on a rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o is high only while the stage is idle.
// On the bus, dmem_req_o and address/data stay constant until the edge that
// samples dmem_ack_i high.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          DATA_W    = mem_stage_pkg::DATA_W,
    parameter int          ADDR_W    = mem_stage_pkg::ADDR_W,
    parameter int          REG_ADR_W = mem_stage_pkg::REG_ADR_W,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [DATA_W-1:0]    req_wdata_i,
    input  logic [REG_ADR_W-1:0] req_rd_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [ADDR_W-1:0]    dmem_addr_o,
    output logic [DATA_W-1:0]    dmem_wdata_o,
    input  logic                 dmem_ack_i,
    input  logic [DATA_W-1:0]    dmem_rdata_i,
    output signal_mem_wr_reg     mem_wr_reg_o,
    output logic                 wb_pending_o,
    output logic                 err_o
);

    mem_state_e       state_q, state_d;
    mem_req_t         req_q, req_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    signal_mem_wr_reg mem_wr_q, mem_wr_d;
    logic             wb_pending_q, wb_pending_d;
    logic             err_q, err_d;

    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_expired;

    logic             accept;
    logic             load_writes_reg;

    assign accept          = (state_q == IDLE) && req_valid_i;
    // rd==0 is the hardwired zero register: the read completes but nothing is written.
    assign load_writes_reg = !req_q.we && (req_q.rd != '0);

    mem_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_enable),
        .expired_o (cnt_expired)
    );

    // State and registered-output flops; reset drops the bus request at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            req_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            mem_wr_q     <= MEM_WR_NONE;
            wb_pending_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            mem_wr_q     <= mem_wr_d;
            wb_pending_q <= wb_pending_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic; an ack on the timeout edge takes priority.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid_i) state_d = REQ;
            REQ: begin
                if (dmem_ack_i) begin
                    state_d = load_writes_reg ? WB : IDLE;
                end else if (cnt_expired) begin
                    state_d = IDLE;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and timeout counter controls.
    always_comb begin
        req_d        = req_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        mem_wr_d     = MEM_WR_NONE;
        wb_pending_d = wb_pending_q;
        err_d        = 1'b0;
        cnt_clear    = 1'b0;
        cnt_enable   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.we     = req_we_i;
                    req_d.addr   = req_addr_i;
                    req_d.wdata  = req_wdata_i;
                    req_d.rd     = req_rd_i;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = req_we_i;
                    wb_pending_d = !req_we_i;
                    cnt_clear    = 1'b1;
                end
            end
            REQ: begin
                if (dmem_ack_i) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    if (load_writes_reg) begin
                        mem_wr_d.ena  = 1'b1;
                        mem_wr_d.adr  = req_q.rd;
                        mem_wr_d.data = dmem_rdata_i;
                    end else begin
                        wb_pending_d = 1'b0;
                    end
                end else if (cnt_expired) begin
                    dmem_req_d   = 1'b0;
                    dmem_we_d    = 1'b0;
                    wb_pending_d = 1'b0;
                    err_d        = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            WB: begin
                wb_pending_d = 1'b0;
            end
            default: begin
                dmem_req_d   = 1'b0;
                dmem_we_d    = 1'b0;
                wb_pending_d = 1'b0;
            end
        endcase
    end

    assign req_ready_o  = (state_q == IDLE);
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = req_q.addr;
    assign dmem_wdata_o = req_q.wdata;
    assign mem_wr_reg_o = mem_wr_q;
    assign wb_pending_o = wb_pending_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus random load/store traffic,
// checked by a scoreboard fed from a transaction-level model of the stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TMO   = 15;
    localparam int BUS_W = 1 + 16 + 16;
    localparam int EV_W  = 2 + 3 + 16;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_we_i;
    logic [15:0]      req_addr_i;
    logic [15:0]      req_wdata_i;
    logic [2:0]       req_rd_i;
    logic             dmem_req_o;
    logic             dmem_we_o;
    logic [15:0]      dmem_addr_o;
    logic [15:0]      dmem_wdata_o;
    logic             dmem_ack_i;
    logic [15:0]      dmem_rdata_i;
    signal_mem_wr_reg mem_wr_reg_o;
    logic             wb_pending_o;
    logic             err_o;

    int vectors     = 0;
    int miscompares = 0;
    bit hold_valid  = 1'b0;

    logic [BUS_W-1:0] bus_q[$];
    logic [EV_W-1:0]  exp_q[$];

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_rd_i     (req_rd_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .mem_wr_reg_o (mem_wr_reg_o),
        .wb_pending_o (wb_pending_o),
        .err_o        (err_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic             prev_req;
        logic [BUS_W-1:0] held_bus;
        logic [BUS_W-1:0] cur_bus;
        logic [EV_W-1:0]  act_ev;
        prev_req = 1'b0;
        held_bus = '0;
        forever begin
            @(negedge clk);
            cur_bus = {dmem_we_o, dmem_addr_o, dmem_wdata_o};
            if (!rst_i) begin
                if (dmem_req_o && !prev_req) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected", 64'(cur_bus), 64'(0));
                    end else begin
                        chk("bus_request", 64'(cur_bus), 64'(bus_q.pop_front()));
                    end
                    held_bus = cur_bus;
                end else if (dmem_req_o) begin
                    chk("bus_stable", 64'(cur_bus), 64'(held_bus));
                end
                if (mem_wr_reg_o.ena) begin
                    chk("pending_during_wb", 64'(wb_pending_o), 64'(1));
                    act_ev = {2'd1, mem_wr_reg_o.adr, mem_wr_reg_o.data};
                    if (exp_q.size() == 0) chk("wb_unexpected", 64'(act_ev), 64'(0));
                    else                   chk("wb_record", 64'(act_ev), 64'(exp_q.pop_front()));
                end else begin
                    chk("wb_idle_zero", 64'({mem_wr_reg_o.adr, mem_wr_reg_o.data}), 64'(0));
                end
                if (err_o) begin
                    act_ev = {2'd2, 3'd0, 16'd0};
                    if (exp_q.size() == 0) chk("err_unexpected", 64'(act_ev), 64'(0));
                    else                   chk("err_event", 64'(act_ev), 64'(exp_q.pop_front()));
                end
            end
            prev_req = dmem_req_o && !rst_i;
        end
    end

    // ---------------- driver ----------------
    // Issues one op, plays the memory with 'delay' wait cycles (no ack at all
    // when delay >= TMO), and checks ready/pending cycle by cycle against the
    // expected transaction timeline.
    task automatic do_op(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [2:0] rd, input int delay, input logic [15:0] rdata);
        int  wt;
        bit  acked;
        bit  wb_load;
        int  done_edge;
        int  ready_edge;
        acked      = (delay < TMO);
        done_edge  = acked ? delay + 1 : TMO;
        wb_load    = !we && acked && (rd != 3'd0);
        ready_edge = wb_load ? done_edge + 1 : done_edge;
        wt = 0;
        while (!req_ready_o) begin
            @(negedge clk);
            wt++;
            if (wt > 50) begin
                chk("ready_wait_timeout", 64'(0), 64'(1));
                return;
            end
        end
        bus_q.push_back({we, addr, wdata});
        if (wb_load)     exp_q.push_back({2'd1, rd, rdata});
        else if (!acked) exp_q.push_back({2'd2, 3'd0, 16'd0});
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_rd_i    = rd;
        @(negedge clk);
        if (!hold_valid) begin
            req_valid_i = 1'b0;
            req_we_i    = 1'($urandom);
            req_addr_i  = 16'($urandom);
            req_wdata_i = 16'($urandom);
            req_rd_i    = 3'($urandom);
        end
        for (int k = 0; k <= ready_edge; k++) begin
            chk("ready_timing", 64'(req_ready_o), 64'(k >= ready_edge));
            chk("wb_pending", 64'(wb_pending_o), 64'(!we && (k < ready_edge)));
            if (k < ready_edge) begin
                dmem_ack_i   = acked && (k == delay);
                dmem_rdata_i = dmem_ack_i ? rdata : 16'($urandom);
                @(negedge clk);
            end else begin
                dmem_ack_i = 1'b0;
            end
        end
        dmem_ack_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sel;
        int dly;
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_rd_i     = '0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready_o), 64'(1));
        chk("rst_bus", 64'({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o}), 64'(0));
        chk("rst_wr_reg", 64'(mem_wr_reg_o), 64'(0));
        chk("rst_flags", 64'({wb_pending_o, err_o}), 64'(0));
        #2 rst_i = 1'b0;
        @(negedge clk);

        // Reset in the middle of a load's bus request.
        bus_q.push_back({1'b0, 16'h0040, 16'h0000});
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 16'h0040;
        req_wdata_i = 16'h0000;
        req_rd_i    = 3'd5;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("t1_req_high", 64'(dmem_req_o), 64'(1));
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        chk("t1_req_drop", 64'(dmem_req_o), 64'(0));
        chk("t1_outputs_zero", 64'({dmem_we_o, dmem_addr_o, dmem_wdata_o, wb_pending_o, err_o}), 64'(0));
        chk("t1_wr_reg_zero", 64'(mem_wr_reg_o), 64'(0));
        chk("t1_ready", 64'(req_ready_o), 64'(1));
        @(negedge clk);
        #2 rst_i = 1'b0;
        @(negedge clk);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 16'h5555;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("t1_late_ack_no_ena", 64'(mem_wr_reg_o.ena), 64'(0));
        chk("t1_late_ack_idle", 64'({req_ready_o, dmem_req_o, wb_pending_o}), 64'(3'b100));
        repeat (2) @(negedge clk);

        // Directed scenarios.
        do_op(1'b0, 16'h0010, 16'h0000, 3'd3, 2, 16'hBEEF);
        do_op(1'b1, 16'h0022, 16'h1234, 3'd1, 0, 16'h0BAD);
        do_op(1'b1, 16'h0024, 16'h5678, 3'd2, 0, 16'h0BAD);
        do_op(1'b0, 16'h0030, 16'h0000, 3'd0, 1, 16'hFFFF);
        do_op(1'b0, 16'h0050, 16'h0000, 3'd6, TMO, 16'h1111);
        do_op(1'b0, 16'h0052, 16'h0000, 3'd2, TMO - 1, 16'hA5A5);
        do_op(1'b1, 16'h0054, 16'h9999, 3'd0, TMO + 3, 16'h0000);

        // Back-to-back with req_valid_i held high.
        hold_valid = 1'b1;
        do_op(1'b0, 16'h0100, 16'h0000, 3'd7, 0, 16'hC0DE);
        do_op(1'b1, 16'h0102, 16'hCAFE, 3'd4, 0, 16'h0000);
        do_op(1'b0, 16'h0104, 16'h0000, 3'd1, 0, 16'hF00D);
        req_valid_i = 1'b0;
        hold_valid  = 1'b0;
        @(negedge clk);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      dly = $urandom_range(0, 4);
            else if (sel == 7) dly = TMO - 1;
            else if (sel == 8) dly = TMO;
            else               dly = TMO + 2;
            do_op(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  3'($urandom_range(0, 7)), dly, 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("bus_q_drained", 64'(bus_q.size()), 64'(0));
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
